// File: rtl/gsram_pkg.sv
// Shared definitions for the gsram controller: FSM state encoding and the
// legal range of the strobe wait-state count.
package gsram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int unsigned WAIT_MIN = 1;
  localparam int unsigned WAIT_MAX = 255;

  function automatic bit wait_cycles_ok(input int unsigned w);
    return (w >= WAIT_MIN) && (w <= WAIT_MAX);
  endfunction

endpackage

// File: rtl/gsram_rr_arb.sv
// Two-input round-robin arbiter; the pointer remembers the last granted port
// and only moves when a grant is actually issued.
module gsram_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic valid,
  output logic gnt
);

  logic last;

  always_comb begin
    valid = en & (req0 | req1);
    // On a tie the port that did not win last time goes first.
    if (req0 && req1) gnt = ~last;
    else              gnt = req1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last <= 1'b1;
    else if (valid) last <= gnt;
  end

endmodule

// File: rtl/gsram_ctrl.sv
// Two-port controller for the asynchronous gsram model: arbitrates, then runs
// SETUP / ACCESS (WAIT_CYCLES strobe cycles) / HOLD with registered strobes.
module gsram_ctrl
  import gsram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sram_read,
  output logic                  sram_write,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  generate
    if (!wait_cycles_ok(WAIT_CYCLES)) begin : g_bad_wait_cycles
      $error("gsram_ctrl: WAIT_CYCLES must be in 1..255");
    end
  endgenerate

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  port;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  data_en;

  logic                  grant_valid;
  logic                  grant;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  gsram_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == IDLE),
    .req0  (req0),
    .req1  (req1),
    .valid (grant_valid),
    .gnt   (grant)
  );

  always_comb begin
    sel_we    = grant ? we1    : we0;
    sel_addr  = grant ? addr1  : addr0;
    sel_wdata = grant ? wdata1 : wdata0;
  end

  assign sram_data = data_en ? wdata_q : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      port       <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      data_en    <= 1'b0;
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
      sram_addr  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            port      <= grant;
            we_q      <= sel_we;
            sram_addr <= sel_addr;
            wdata_q   <= sel_wdata;
            data_en   <= sel_we;
            state     <= SETUP;
          end
        end
        SETUP: begin
          sram_read  <= ~we_q;
          sram_write <= we_q;
          cnt        <= CNT_W'(WAIT_CYCLES - 1);
          state      <= ACCESS;
        end
        ACCESS: begin
          if (cnt == '0) begin
            sram_read  <= 1'b0;
            sram_write <= 1'b0;
            ack0       <= ~port;
            ack1       <= port;
            if (!we_q) rdata <= sram_data;
            state      <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          // Write data is kept on the bus through HOLD for SRAM hold time.
          data_en <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsram_ctrl.sv
// Bench for gsram_ctrl: transaction-level model plus per-cycle compare on the
// WAIT_CYCLES=3 instance, and a directed round-trip on a WAIT_CYCLES=1 instance.
module tb_gsram_ctrl;

  localparam int W = 3;

  logic        clk = 1'b0, clk_b = 1'b0, rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, sram_read, sram_write;
  logic [15:0] rdata, sram_addr;
  wire  [15:0] sram_data;

  logic        req_b = 0, we_b = 0, ack0_b, ack1_b, sram_read_b, sram_write_b;
  logic [15:0] addr_b = 0, wdata_b = 0, rdata_b, sram_addr_b;
  wire  [15:0] sram_data_b;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, cyc_b = 0;

  always #5 clk = ~clk;
  always begin #12 clk_b = ~clk_b; #13 clk_b = ~clk_b; end

  gsram_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .sram_read(sram_read),
    .sram_write(sram_write), .sram_addr(sram_addr), .sram_data(sram_data));

  gsram_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_CYCLES(1)) dut_b (
    .clk(clk_b), .rst_n(rst_n), .req0(req_b), .req1(1'b0), .we0(we_b), .we1(1'b0),
    .addr0(addr_b), .addr1(16'h0), .wdata0(wdata_b), .wdata1(16'h0),
    .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b), .sram_read(sram_read_b),
    .sram_write(sram_write_b), .sram_addr(sram_addr_b), .sram_data(sram_data_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Asynchronous SRAM models (256 words, 20-unit read access time)
  logic [15:0] mem_a [256], mem_b [256];
  logic        drv_a = 0, drv_b = 0;
  logic [15:0] dval_a = 0, dval_b = 0, wl_a = 0, wd_a = 0, wl_b = 0, wd_b = 0;
  assign sram_data   = drv_a ? dval_a : 'z;
  assign sram_data_b = drv_b ? dval_b : 'z;

  always @(posedge sram_read) begin
    #20;
    if (sram_read) begin
      dval_a = (sram_addr < 16'd256) ? mem_a[sram_addr[7:0]] : 'x;
      drv_a  = 1'b1;
    end
  end
  always @(negedge sram_read) begin #1 drv_a = 1'b0; end
  always @(posedge sram_write) begin wl_a = sram_addr; wd_a = sram_data; end
  always @(negedge sram_write) if (wl_a < 16'd256) mem_a[wl_a[7:0]] = wd_a;

  always @(posedge sram_read_b) begin
    #20;
    if (sram_read_b) begin
      dval_b = (sram_addr_b < 16'd256) ? mem_b[sram_addr_b[7:0]] : 'x;
      drv_b  = 1'b1;
    end
  end
  always @(negedge sram_read_b) begin #1 drv_b = 1'b0; end
  always @(posedge sram_write_b) begin wl_b = sram_addr_b; wd_b = sram_data_b; end
  always @(negedge sram_write_b) if (wl_b < 16'd256) mem_b[wl_b[7:0]] = wd_b;

  // Transaction-level model: one access at a time, W+3 edges per access
  logic        m_active = 0, m_last = 1, m_port = 0, m_we = 0;
  logic [15:0] m_addr = 0, m_wdata = 0, exp_addr = 0, exp_rdata = 0;
  logic        rdata_known = 1;
  int          m_g = 0;
  logic [15:0] ref_mem [256];
  bit          ref_known [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (m_active && m_we && m_addr < 16'd256) ref_known[m_addr[7:0]] = 1'b0;
      m_active = 0; m_last = 1; exp_addr = 0; exp_rdata = 0; rdata_known = 1;
    end else begin
      cyc++;
      if (!m_active) begin
        if (req0 || req1) begin
          m_port   = (req0 && req1) ? ~m_last : req1;
          m_last   = m_port;
          m_we     = m_port ? we1 : we0;
          m_addr   = m_port ? addr1 : addr0;
          m_wdata  = m_port ? wdata1 : wdata0;
          exp_addr = m_addr;
          m_g      = cyc;
          m_active = 1;
        end
      end else if (cyc == m_g + W + 1) begin
        if (m_we) begin
          if (m_addr < 16'd256) begin
            ref_mem[m_addr[7:0]] = m_wdata; ref_known[m_addr[7:0]] = 1'b1;
          end
        end else if (m_addr < 16'd256 && ref_known[m_addr[7:0]]) begin
          exp_rdata = ref_mem[m_addr[7:0]]; rdata_known = 1;
        end else begin
          rdata_known = 0;
        end
      end else if (cyc == m_g + W + 2) begin
        m_active = 0;
      end
    end
  end

  always @(posedge clk_b) cyc_b++;

  // Per-cycle compare plus strobe-protocol checks
  logic        prev_strobe = 0, seen_strobe = 0;
  int          low_cnt = 0;
  logic [15:0] addr_at = 0, data_at = 0;

  always @(negedge clk) begin
    logic ex_strobe;
    ex_strobe = m_active && (cyc >= m_g + 1) && (cyc <= m_g + W);
    check("ack0",       ack0,       m_active && cyc == m_g + W + 1 && !m_port);
    check("ack1",       ack1,       m_active && cyc == m_g + W + 1 && m_port);
    check("sram_read",  sram_read,  ex_strobe && !m_we);
    check("sram_write", sram_write, ex_strobe && m_we);
    check("sram_addr",  sram_addr,  exp_addr);
    if (rdata_known) check("rdata", rdata, exp_rdata);
    check("strobe_excl", sram_read && sram_write, 1'b0);
    if (sram_read || sram_write) begin
      if (!prev_strobe) begin
        if (seen_strobe) check("strobe_gap", low_cnt >= 2, 1'b1);
        addr_at = sram_addr; data_at = sram_data; seen_strobe = 1;
      end else begin
        check("addr_stable", sram_addr, addr_at);
        if (sram_write) check("data_stable", sram_data, data_at);
      end
      low_cnt = 0;
    end else begin
      low_cnt++;
    end
    prev_strobe = sram_read || sram_write;
  end

  task automatic access(input bit p, input bit w, input logic [15:0] a,
                        input logic [15:0] d, output int lat);
    int start, n;
    @(negedge clk);
    if (!p) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else    begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    start = cyc; n = 0;
    do begin @(negedge clk); n++; end while (!(p ? ack1 : ack0) && n < 50);
    check("ack_wait", n < 50, 1'b1);
    lat = cyc - start;
    req0 = 0; req1 = 0;
    $display("port%0d %s addr=%h wdata=%h rdata=%h latency=%0d", p, w ? "WR" : "RD", a, d, rdata, lat);
  endtask

  task automatic access_b(input bit w, input logic [15:0] a, input logic [15:0] d, output int lat);
    int start, n;
    @(negedge clk_b);
    req_b = 1; we_b = w; addr_b = a; wdata_b = d;
    start = cyc_b; n = 0;
    do begin @(negedge clk_b); n++; end while (!ack0_b && n < 50);
    check("ack_b_wait", n < 50, 1'b1);
    lat = cyc_b - start;
    req_b = 0;
    $display("W1 %s addr=%h wdata=%h rdata=%h latency=%0d", w ? "WR" : "RD", a, d, rdata_b, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, k;
    int          at [4];
    logic [1:0]  order [4];
    logic        exp_order [4];
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_sram_addr", sram_addr, 16'h0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_strobes", {sram_read, sram_write, ack0, ack1}, 4'b0);
    @(negedge clk); rst_n = 1;

    // Both ports hold write requests: port 0 must win the first tie
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 16'h30; wdata0 = 16'h1111;
    req1 = 1; we1 = 1; addr1 = 16'h31; wdata1 = 16'h2222;
    n = 0; k = 0;
    while (k < 4 && n < 100) begin
      @(negedge clk); n++;
      if (ack0 || ack1) begin order[k] = {1'b0, ack1}; at[k] = cyc; k++; end
    end
    req0 = 0; req1 = 0;
    check("rr_count", k, 4);
    for (int i = 0; i < 4; i++) begin
      check("rr_order", order[i], {1'b0, exp_order[i]});
      if (i > 0) check("rr_span", at[i] - at[i-1], 6);
      $display("rr grant %0d -> port%0d at cycle %0d", i, order[i], at[i]);
    end

    access(0, 1, 16'h10, 16'hA5A5, lat); check("wr_latency", lat, 5);
    access(0, 0, 16'h10, 16'h0, lat);    check("rd_latency", lat, 5);
    check("rd_a5a5", rdata, 16'hA5A5);
    access(1, 0, 16'h30, 16'h0, lat);    check("rd_p1_30", rdata, 16'h1111);
    access(1, 0, 16'h31, 16'h0, lat);    check("rd_p1_31", rdata, 16'h2222);

    access(1, 1, 16'h0, 16'h5A5A, lat);
    access(0, 0, 16'h0100, 16'h0, lat);  check("oor_latency", lat, 5);
    access(0, 0, 16'h0, 16'h0, lat);     check("loc0_intact", rdata, 16'h5A5A);

    // Reset in the middle of a write's strobe window
    access(0, 1, 16'h20, 16'h1111, lat);
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 16'h20; wdata0 = 16'h2222;
    n = 0;
    while (!sram_write && n < 20) begin @(negedge clk); n++; end
    check("rst_wait_strobe", sram_write, 1'b1);
    @(negedge clk); #2 rst_n = 0; req0 = 0;
    #1;
    check("abort_strobes", {sram_read, sram_write, ack0, ack1}, 4'b0);
    check("abort_addr", sram_addr, 16'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    access(0, 0, 16'h20, 16'h0, lat);
    check("abort_read", (rdata === 16'h1111) || (rdata === 16'h2222), 1'b1);

    // WAIT_CYCLES=1 instance on the 25-unit clock
    access_b(1, 16'h12, 16'h1234, lat); check("w1_wr_latency", lat, 3);
    access_b(0, 16'h12, 16'h0, lat);    check("w1_rd_latency", lat, 3);
    check("w1_rdata", rdata_b, 16'h1234);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gsram_ctrl.md
# gsram_ctrl

Synchronous two-port controller for the asynchronous `gsram` memory model. It arbitrates between two clocked requesters and sequences the SRAM `read`/`write` strobes, address and tri-state data bus with programmable wait states. It returns an acknowledge and read data to the granted requester. It sits between on-chip bus masters and the `gsram` instance, replacing hand-written strobe sequencing in benches and top-levels.

## Interface
- `ADDR_WIDTH`, 16: SRAM address width.
- `DATA_WIDTH`, 16: SRAM data width.
- `WAIT_CYCLES`, 3: number of clock cycles a strobe is held; must satisfy WAIT_CYCLES x Tclk > gsram WAIT_TIME + 1 ns; legal range 1..255.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  controller clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0`, `req1`  in  1  access request per port; held until that port's ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; held with req.
- `addr0`, `addr1`  in  ADDR_WIDTH  access address; held with req.
- `wdata0`, `wdata1`  in  DATA_WIDTH  write data; held with req.
- `ack0`, `ack1`  out  1  single-cycle completion pulse per port.
- `rdata`  out  DATA_WIDTH  read data, valid in the ack cycle of a read; holds until the next read completes.
- `sram_read`  out  1  to gsram `read`.
- `sram_write`  out  1  to gsram `write`.
- `sram_addr`  out  ADDR_WIDTH  to gsram `address`.
- `sram_data`  inout  DATA_WIDTH  to gsram `data`; driven only during write transactions, otherwise `'z`.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE: arbitrate. If any req is high, latch the grant, we, addr and wdata of the winner, then go to SETUP. Otherwise stay.
- SETUP (1 cycle): drive `sram_addr`; for writes, drive `sram_data`. Both strobes stay low.
- ACCESS (WAIT_CYCLES cycles):
  - Assert exactly one strobe: `sram_write` if the latched we is 1, else `sram_read`.
  - A down-counter, loaded with WAIT_CYCLES-1 on SETUP->ACCESS, counts to 0.
  - For reads, `sram_data` is captured into `rdata` on the clock edge that leaves ACCESS.
- HOLD (1 cycle):
  - Both strobes low. Address stays driven; write data stays driven (hold time), then is released on exit.
  - Assert `ack` of the granted port. Go to IDLE.
- Arbitration is round-robin. With both req high, the port not granted last wins. With one req high, it wins. The last-grant pointer updates on each grant.
- A req still high in the IDLE cycle after its ack is a new request.
- Never assert both strobes together. Never change `sram_addr` or driven data while a strobe is high.
- Strobes, ack and data enable are registered outputs (glitch-free).
- Address range checking belongs to gsram; the controller does not filter addresses.

## Timing
- Reset values (async on `rst_n` low, effective immediately, including mid-transaction):
  - state IDLE; `sram_read`, `sram_write`, `ack0`, `ack1` = 0.
  - `sram_addr` = 0, `rdata` = 0, `sram_data` released.
  - Last-grant pointer = port 1, so port 0 wins the first tie.
- An aborted access is dropped with no ack; requesters re-request after reset.
- Latency: req sampled high in IDLE at edge N -> SETUP in N..N+1, ACCESS for WAIT_CYCLES cycles, ack high during cycle N+WAIT_CYCLES+2.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- Between consecutive accesses, strobes are low for at least 2 cycles (HOLD and IDLE). This guarantees a fresh gsram transaction pulse.
- req/we/addr/wdata changes after the grant are ignored until ack.

## Structure
- Shared package `gsram_pkg`: FSM state encodings (2-bit) and the WAIT_CYCLES legality check.
- Sub-module `gsram_rr_arb`: 2-input round-robin arbiter with last-grant pointer, enabled only in IDLE.
- Counter width is $clog2(WAIT_CYCLES+1).

## Test plan
Bench uses gsram(START_ADDR=0, SIZE=256, WAIT_TIME=20), 10 ns clock, WAIT_CYCLES=3.
- Single write then read: port 0 writes 16'hA5A5 @ 8'h10, then reads @ 8'h10 -> each ack0 arrives 5 cycles after req; rdata = 16'hA5A5.
- Simultaneous req0 and req1 held continuously, both writing distinct data -> grants alternate 0,1,0,1; no cycle has both strobes high; each transaction spans 6 cycles.
- Read of out-of-range address 16'h0100 -> ack after 5 cycles; rdata = 'z/x as returned by gsram; no corruption of location 0.
- Strobe checker over all tests: address and data stable whenever a strobe is high; at least 2 low cycles between strobes.
- Assert rst_n low during ACCESS of a write to 8'h20 -> strobes drop immediately, bus released, no ack; after reset a read of 8'h20 returns the prior value or the new value, never a bus contention X.
- WAIT_CYCLES=1 with 25 ns clock -> write/read 16'h1234 round-trips correctly; ack 3 cycles after req.
